// File: rtl/stream_frame_delimiter.sv
// Frames a raw UART byte stream into data/valid/last beats, holding one byte back so
// last lands on the final payload byte. Optional idle flush: define FRAME_TIMEOUT_EN.
module stream_frame_delimiter #(
  parameter logic [7:0] TERMINATOR     = 8'h0A,
  parameter int         MAX_FRAME_LEN  = 64,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic       overflow,
  output logic [1:0] state_dbg
);

  // Handshake: rx_valid is a one-cycle strobe with no ready; every out_valid beat is
  // consumed by downstream in the cycle it is presented (no backpressure).

  localparam int LEN_W = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]       state, state_nx;
  logic [7:0]       hold, hold_nx;
  logic [LEN_W-1:0] frame_len, frame_len_nx;
  logic             emit, emit_last, emit_ovf;
  logic             byte_evt, is_term;
  logic             timeout_hit;

  assign byte_evt  = enable & rx_valid;
  assign is_term   = (rx_data == TERMINATOR);
  assign state_dbg = state;

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt, to_cnt_nx;

  // A strobe in the expiry cycle wins; the flush only fires on a quiet cycle.
  assign timeout_hit = enable && !rx_valid && (state == ST_HOLD) && (to_cnt == TO_LIMIT);

  always_comb begin
    to_cnt_nx = to_cnt;
    if (enable) begin
      if ((state_nx != state) || rx_valid) begin
        to_cnt_nx = '0;
      end else if (state == ST_HOLD) begin
        to_cnt_nx = to_cnt + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt_nx;
    end
  end
`else
  // Without the flush a held byte waits for the next byte or terminator.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    hold_nx      = hold;
    frame_len_nx = frame_len;
    emit         = 1'b0;
    emit_last    = 1'b0;
    emit_ovf     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A terminator here would close an empty frame, which is simply dropped.
        if (byte_evt && !is_term) begin
          hold_nx      = rx_data;
          frame_len_nx = LEN_ONE;
          state_nx     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (byte_evt) begin
          emit = 1'b1;
          if (is_term) begin
            emit_last    = 1'b1;
            frame_len_nx = '0;
            state_nx     = ST_IDLE;
          end else if (frame_len < LEN_MAX) begin
            hold_nx      = rx_data;
            frame_len_nx = frame_len + LEN_ONE;
          end else begin
            // Frame is full: close it on the held byte and drop the rest.
            emit_last    = 1'b1;
            emit_ovf     = 1'b1;
            frame_len_nx = '0;
            state_nx     = ST_DISCARD;
          end
        end else if (timeout_hit) begin
          emit         = 1'b1;
          emit_last    = 1'b1;
          frame_len_nx = '0;
          state_nx     = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (byte_evt && is_term) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx     = ST_IDLE;
        frame_len_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hold      <= 8'h00;
      frame_len <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      hold      <= hold_nx;
      frame_len <= frame_len_nx;
      out_valid <= emit;
      out_last  <= emit_last;
      overflow  <= emit_ovf;
      if (emit) begin
        out_data <= hold;
      end
    end
  end

endmodule

// File: tb/tb_stream_frame_delimiter.sv
// Directed bench for stream_frame_delimiter: cycle tables plus hand-written reset,
// enable and idle-flush sequences on a default instance and a MAX_FRAME_LEN=4 instance.
module tb_stream_frame_delimiter;

  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic       eo;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_last, b_last, a_ovf, b_ovf;
  logic [1:0] a_state, b_state;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  stream_frame_delimiter #(.TIMEOUT_CYCLES(10)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(a_data), .out_valid(a_valid), .out_last(a_last), .overflow(a_ovf),
    .state_dbg(a_state)
  );

  stream_frame_delimiter #(.MAX_FRAME_LEN(4), .TIMEOUT_CYCLES(10)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(b_data), .out_valid(b_valid), .out_last(b_last), .overflow(b_ovf),
    .state_dbg(b_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic drive(input logic en, input logic v, input logic [7:0] d);
    @(negedge clock);
    enable   = en;
    rx_valid = v;
    rx_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b0;
    enable   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic void add(input logic en, input logic v, input logic [7:0] d,
                              input logic ev, input logic [7:0] ed, input logic el,
                              input logic eo);
    vec_t r;
    r.en = en; r.v = v; r.d = d; r.ev = ev; r.ed = ed; r.el = el; r.eo = eo;
    tbl.push_back(r);
  endfunction

  // scoreboard compare: data/last only matter on a valid beat
  task automatic check(input string name, input bit sel, input logic ev,
                       input logic [7:0] ed, input logic el, input logic eo);
    logic [7:0] d;
    logic v, l, o;
    bit ok;
    d = sel ? b_data : a_data;
    v = sel ? b_valid : a_valid;
    l = sel ? b_last : a_last;
    o = sel ? b_ovf : a_ovf;
    ok = (v === ev) && (o === eo) && (!ev || ((d === ed) && (l === el)));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got valid=%b data=%h last=%b ovf=%b, want valid=%b data=%h last=%b ovf=%b",
               name, v, d, l, o, ev, ed, el, eo);
    end
  endtask

  task automatic check_state(input string name, input bit sel, input logic [1:0] want);
    logic [1:0] got;
    got = sel ? b_state : a_state;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got state=%0d want state=%0d", name, got, want);
    end
  endtask

  task automatic run_table(input string name, input bit sel);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].d);
      check($sformatf("%s[%0d]", name, i), sel, tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eo);
    end
    tbl.delete();
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("reset_a", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_b", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_state("reset_state_a", 1'b0, 2'd0);
    checks++;
    if (a_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %h want 00", a_data);
    end
    @(negedge clock);
    reset = 1'b1;

    // "hello\n" with a gap after each byte
    add(1, 1, 8'h68, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(1, 1, 8'h65, 1, 8'h68, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(1, 1, 8'h6C, 1, 8'h65, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(1, 1, 8'h6C, 1, 8'h6C, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(1, 1, 8'h6F, 1, 8'h6C, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(1, 1, 8'h0A, 1, 8'h6F, 1, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    run_table("hello", 1'b0);

    // "\n\nab\n": empty frames produce nothing
    add(1, 1, 8'h0A, 0, 8'h00, 0, 0);
    add(1, 1, 8'h0A, 0, 8'h00, 0, 0);
    add(1, 1, 8'h61, 0, 8'h00, 0, 0);
    add(1, 1, 8'h62, 1, 8'h61, 0, 0);
    add(1, 1, 8'h0A, 1, 8'h62, 1, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    run_table("empty", 1'b0);

    // MAX_FRAME_LEN=4: "abcdef\nxy\n" then exactly-full "abcd\n"
    do_reset();
    add(1, 1, 8'h61, 0, 8'h00, 0, 0);
    add(1, 1, 8'h62, 1, 8'h61, 0, 0);
    add(1, 1, 8'h63, 1, 8'h62, 0, 0);
    add(1, 1, 8'h64, 1, 8'h63, 0, 0);
    add(1, 1, 8'h65, 1, 8'h64, 1, 1);
    add(1, 1, 8'h66, 0, 8'h00, 0, 0);
    add(1, 1, 8'h0A, 0, 8'h00, 0, 0);
    add(1, 1, 8'h78, 0, 8'h00, 0, 0);
    add(1, 1, 8'h79, 1, 8'h78, 0, 0);
    add(1, 1, 8'h0A, 1, 8'h79, 1, 0);
    add(1, 1, 8'h61, 0, 8'h00, 0, 0);
    add(1, 1, 8'h62, 1, 8'h61, 0, 0);
    add(1, 1, 8'h63, 1, 8'h62, 0, 0);
    add(1, 1, 8'h64, 1, 8'h63, 0, 0);
    add(1, 1, 8'h0A, 1, 8'h64, 1, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    run_table("maxlen", 1'b1);

    // mid-frame asynchronous reset
    do_reset();
    drive(1, 1, 8'h61);
    check("rst_a", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1, 8'h62);
    check("rst_b", 1'b0, 1'b1, 8'h61, 1'b0, 1'b0);
    drive(1, 1, 8'h63);
    check("rst_c", 1'b0, 1'b1, 8'h62, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_state("rst_async_state", 1'b0, 2'd0);
    @(negedge clock);
    rx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    drive(1, 0, 8'h00);
    check("rst_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1, 8'h7A);
    check("rst_z", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1, 8'h0A);
    check("rst_term", 1'b0, 1'b1, 8'h7A, 1'b1, 1'b0);

    // enable low: strobes are lost
    add(0, 1, 8'h71, 0, 8'h00, 0, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 8'h0A, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    add(1, 1, 8'h72, 0, 8'h00, 0, 0);
    add(0, 1, 8'h73, 0, 8'h00, 0, 0);
    add(1, 1, 8'h0A, 1, 8'h72, 1, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0, 0);
    run_table("enable", 1'b0);

`ifdef FRAME_TIMEOUT_EN
    drive(1, 1, 8'h6B);
    check("to_k", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 8'h00);
      check($sformatf("to_wait[%0d]", i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    drive(1, 0, 8'h00);
    check("to_flush", 1'b0, 1'b1, 8'h6B, 1'b1, 1'b0);
    check_state("to_state", 1'b0, 2'd0);
    drive(1, 1, 8'h0A);
    check("to_term", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`else
    drive(1, 1, 8'h6B);
    check("hold_k", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 8'h00);
      check($sformatf("hold_wait[%0d]", i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    check_state("hold_state", 1'b0, 2'd1);
    drive(1, 1, 8'h0A);
    check("hold_term", 1'b0, 1'b1, 8'h6B, 1'b1, 1'b0);
`endif
    drive(1, 0, 8'h00);
    check("final_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
